// File: rtl/csr_trap_if.sv
// csr_trap_if: CSR access, trap request and fetch-redirect signals between the pipeline
// (master) and csr_trap_unit (slave).
interface csr_trap_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  logic            exc_valid;
  logic [4:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;

  logic            irq_window;
  logic [XLEN-1:0] irq_pc;
  logic            irq_ext;
  logic            irq_timer;
  logic            irq_sw;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    output csr_we, csr_addr, csr_wdata,
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
    output irq_window, irq_pc, irq_ext, irq_timer, irq_sw,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata,
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
    input  irq_window, irq_pc, irq_ext, irq_timer, irq_sw,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with exception/interrupt entry and MRET sequencing.
// Define TRAP_VECTORED_EN to enable mtvec.mode=1 (vectored interrupt targets).
module csr_trap_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     HART_ID   = 0,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  csr_trap_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSave, StRestore, StRedir} state_e;

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMisa      = 12'h301;
  localparam logic [11:0] AddrMie       = 12'h304;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMtval     = 12'h343;
  localparam logic [11:0] AddrMip       = 12'h344;
  localparam logic [11:0] AddrMvendorid = 12'hF11;
  localparam logic [11:0] AddrMarchid   = 12'hF12;
  localparam logic [11:0] AddrMimpid    = 12'hF13;
  localparam logic [11:0] AddrMhartid   = 12'hF14;

  state_e          state_q, state_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]      mie_q, mie_d;  // {MEIE, MTIE, MSIE}
  logic [XLEN-3:0] mtvec_base_q, mtvec_base_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            is_mret_q, is_mret_d;
  logic            mtvec_mode;

`ifdef TRAP_VECTORED_EN
  logic mtvec_mode_q, mtvec_mode_d;
  assign mtvec_mode = mtvec_mode_q;
`else
  assign mtvec_mode = 1'b0;
`endif

  logic [2:0]      irq_pending;
  logic            irq_req;
  logic [4:0]      irq_cause;
  logic            exc_take, mret_take, irq_take, trap_take;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_base, trap_target;

  assign irq_pending = {bus.irq_ext, bus.irq_timer, bus.irq_sw} & mie_q;
  assign irq_req     = bus.irq_window && mstatus_mie_q && (irq_pending != 3'b000);
  // MEI outranks MSI, which outranks MTI.
  assign irq_cause   = irq_pending[2] ? 5'd11 : (irq_pending[0] ? 5'd3 : 5'd7);

  assign exc_take  = bus.exc_valid;
  assign mret_take = !bus.exc_valid && bus.mret_valid;
  assign irq_take  = !bus.exc_valid && !bus.mret_valid && irq_req;
  assign trap_take = exc_take || irq_take;
  assign trap_pc   = exc_take ? bus.exc_pc : bus.irq_pc;

  // CSR read mux and legality.
  always_comb begin
    bus.csr_rdata   = '0;
    bus.csr_illegal = 1'b0;
    case (bus.csr_addr)
      AddrMstatus: begin
        bus.csr_rdata[12:11] = 2'b11;
        bus.csr_rdata[7]     = mstatus_mpie_q;
        bus.csr_rdata[3]     = mstatus_mie_q;
      end
      AddrMisa: begin
        bus.csr_rdata[XLEN-1:XLEN-2] = 2'b01;
        bus.csr_rdata[8]             = 1'b1;
      end
      AddrMie: begin
        bus.csr_rdata[11] = mie_q[2];
        bus.csr_rdata[7]  = mie_q[1];
        bus.csr_rdata[3]  = mie_q[0];
      end
      AddrMtvec:    bus.csr_rdata = {mtvec_base_q, 1'b0, mtvec_mode};
      AddrMscratch: bus.csr_rdata = mscratch_q;
      AddrMepc:     bus.csr_rdata = mepc_q;
      AddrMcause:   bus.csr_rdata = mcause_q;
      AddrMtval:    bus.csr_rdata = mtval_q;
      AddrMip: begin
        bus.csr_rdata[11] = bus.irq_ext;
        bus.csr_rdata[7]  = bus.irq_timer;
        bus.csr_rdata[3]  = bus.irq_sw;
        bus.csr_illegal   = bus.csr_we;
      end
      AddrMvendorid, AddrMarchid, AddrMimpid: bus.csr_illegal = bus.csr_we;
      AddrMhartid: begin
        bus.csr_rdata   = XLEN'(HART_ID);
        bus.csr_illegal = bus.csr_we;
      end
      default: bus.csr_illegal = 1'b1;
    endcase
  end

  // Next-state: FSM transitions, trap/MRET side effects and CSR writes.
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_base_d   = mtvec_base_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    is_mret_d      = is_mret_q;
`ifdef TRAP_VECTORED_EN
    mtvec_mode_d   = mtvec_mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (trap_take) begin
          state_d        = StSave;
          is_mret_d      = 1'b0;
          mepc_d         = {trap_pc[XLEN-1:2], 2'b00};
          mcause_d       = {irq_take, {(XLEN-6){1'b0}}, irq_take ? irq_cause : bus.exc_cause};
          mtval_d        = exc_take ? bus.exc_tval : '0;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
          state_d        = StRestore;
          is_mret_d      = 1'b1;
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
        end else if (bus.csr_we && !bus.csr_illegal) begin
          case (bus.csr_addr)
            AddrMstatus: begin
              mstatus_mie_d  = bus.csr_wdata[3];
              mstatus_mpie_d = bus.csr_wdata[7];
            end
            AddrMie: mie_d = {bus.csr_wdata[11], bus.csr_wdata[7], bus.csr_wdata[3]};
            AddrMtvec: begin
              mtvec_base_d = bus.csr_wdata[XLEN-1:2];
`ifdef TRAP_VECTORED_EN
              // Reserved modes 2/3 leave the current mode in place.
              if (!bus.csr_wdata[1]) mtvec_mode_d = bus.csr_wdata[0];
`endif
            end
            AddrMscratch: mscratch_d = bus.csr_wdata;
            AddrMepc:     mepc_d     = {bus.csr_wdata[XLEN-1:2], 2'b00};
            AddrMcause:   mcause_d   = bus.csr_wdata;
            AddrMtval:    mtval_d    = bus.csr_wdata;
            default: ;
          endcase
        end
      end
      StSave, StRestore: state_d = StRedir;
      StRedir:           state_d = StIdle;
      default:           state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_base_q   <= RESET_VEC[XLEN-1:2];
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      is_mret_q      <= 1'b0;
`ifdef TRAP_VECTORED_EN
      mtvec_mode_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_base_q   <= mtvec_base_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      is_mret_q      <= is_mret_d;
`ifdef TRAP_VECTORED_EN
      mtvec_mode_q   <= mtvec_mode_d;
`endif
    end
  end

  // mtvec/mepc/mcause are frozen outside IDLE, so the target is stable while in REDIR.
  assign trap_base   = {mtvec_base_q, 2'b00};
  assign trap_target = (mtvec_mode && mcause_q[XLEN-1])
                     ? trap_base + {{(XLEN-7){1'b0}}, mcause_q[4:0], 2'b00}
                     : trap_base;

  assign bus.redirect_valid = (state_q == StRedir);
  assign bus.redirect_pc    = is_mret_q ? mepc_q : trap_target;
  assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed and randomized checks of csr_trap_unit against a
// transaction-level model of the machine-mode CSRs.
module tb_csr_trap_unit;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned HART_ID   = 5;
  localparam logic [31:0] RESET_VEC = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  // Architectural reference state.
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  logic [11:0] addr_tbl [13] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14};

  csr_trap_if #(.XLEN(XLEN)) bus ();

  csr_trap_unit #(
    .XLEN     (XLEN),
    .HART_ID  (HART_ID),
    .RESET_VEC(RESET_VEC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = RESET_VEC;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endfunction

  function automatic bit is_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                     12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
  endfunction

  function automatic bit model_illegal(input logic [11:0] a, input bit we);
    return !is_impl(a) || (we && (a inside {12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14}));
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (bus.irq_ext ? 32'h800 : 32'h0) | (bus.irq_timer ? 32'h80 : 32'h0)
                    | (bus.irq_sw ? 32'h8 : 32'h0);
      12'hF14: return 32'(HART_ID);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] mode;
    if (model_illegal(a, 1'b1)) return;
    case (a)
      12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
      12'h304: m_mie_reg = d & 32'h888;
      12'h305: begin
`ifdef TRAP_VECTORED_EN
        mode = d % 4;
        if (mode > 1) mode = m_mtvec % 4;
`else
        mode = 0;
`endif
        m_mtvec = (d & ~32'h3) | mode;
      end
      12'h340: m_mscratch = d;
      12'h341: m_mepc = d & ~32'h3;
      12'h342: m_mcause = d;
      12'h343: m_mtval = d;
      default: ;
    endcase
  endfunction

  function automatic void model_trap(input bit is_irq, input int unsigned cause,
                                     input logic [31:0] pc, input logic [31:0] tval);
    m_mepc   = pc & ~32'h3;
    m_mcause = (is_irq ? 32'h8000_0000 : 32'h0) + cause;
    m_mtval  = is_irq ? 32'h0 : tval;
    m_mpie   = m_mie;
    m_mie    = 0;
  endfunction

  function automatic logic [31:0] model_trap_target();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mcause >= 32'h8000_0000 && (m_mtvec % 4) == 1) return base + 4 * (m_mcause % 32);
    return base;
  endfunction

  task automatic csr_read_check(input logic [11:0] a, input string tag);
    @(negedge clk);
    bus.csr_we   = 1'b0;
    bus.csr_addr = a;
    #1;
    check($sformatf("%s rdata", tag), bus.csr_rdata, model_read(a));
    check($sformatf("%s illegal", tag), 32'(bus.csr_illegal), 32'(model_illegal(a, 1'b0)));
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    bus.csr_we    = 1'b1;
    #1;
    check($sformatf("wr %03h illegal", a), 32'(bus.csr_illegal), 32'(model_illegal(a, 1'b1)));
    @(posedge clk);
    model_write(a, d);
    #1 bus.csr_we = 1'b0;
  endtask

  // Called just before the edge that samples a request; redirect must appear two cycles on.
  task automatic expect_redirect(input logic [31:0] exp_pc, input string tag);
    @(posedge clk);
    #1;
    bus.exc_valid  = 1'b0;
    bus.mret_valid = 1'b0;
    bus.irq_window = 1'b0;
    // A write issued while busy has to be dropped.
    bus.csr_we     = 1'b1;
    bus.csr_addr   = 12'h340;
    bus.csr_wdata  = $urandom;
    @(negedge clk);
    check($sformatf("%s n+1 redirect_valid", tag), 32'(bus.redirect_valid), 32'd0);
    check($sformatf("%s n+1 busy", tag), 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 bus.csr_we = 1'b0;
    @(negedge clk);
    check($sformatf("%s n+2 redirect_valid", tag), 32'(bus.redirect_valid), 32'd1);
    check($sformatf("%s redirect_pc", tag), bus.redirect_pc, exp_pc);
    @(negedge clk);
    check($sformatf("%s n+3 redirect_valid", tag), 32'(bus.redirect_valid), 32'd0);
    check($sformatf("%s n+3 busy", tag), 32'(bus.busy), 32'd0);
  endtask

  task automatic do_exception(input int unsigned cause, input logic [31:0] pc,
                              input logic [31:0] tval, input bit with_mret, input bit with_wr,
                              input logic [31:0] wr_data, input string tag);
    @(negedge clk);
    bus.exc_valid  = 1'b1;
    bus.exc_cause  = 5'(cause);
    bus.exc_pc     = pc;
    bus.exc_tval   = tval;
    bus.mret_valid = with_mret;
    if (with_wr) begin
      bus.csr_we    = 1'b1;
      bus.csr_addr  = 12'h340;
      bus.csr_wdata = wr_data;
    end
    model_trap(1'b0, cause, pc, tval);
    expect_redirect(model_trap_target(), tag);
  endtask

  task automatic do_mret(input string tag);
    @(negedge clk);
    bus.mret_valid = 1'b1;
    m_mie  = m_mpie;
    m_mpie = 1;
    expect_redirect(m_mepc, tag);
  endtask

  // Caller guarantees MIE=1 and that some raised line is enabled.
  task automatic do_irq(input bit ext, input bit tmr, input bit sw, input logic [31:0] pc,
                        input string tag);
    int unsigned cause;
    @(negedge clk);
    bus.irq_ext   = ext;
    bus.irq_timer = tmr;
    bus.irq_sw    = sw;
    bus.irq_pc    = pc;
    #1;
    check($sformatf("%s no take w/o window", tag), 32'(bus.busy), 32'd0);
    @(negedge clk);
    check($sformatf("%s idle w/o window", tag), 32'(bus.busy), 32'd0);
    bus.irq_window = 1'b1;
    if (ext && m_mie_reg[11]) cause = 11;
    else if (sw && m_mie_reg[3]) cause = 3;
    else cause = 7;
    model_trap(1'b1, cause, pc, 32'h0);
    expect_redirect(model_trap_target(), tag);
    @(negedge clk);
    bus.irq_ext   = 1'b0;
    bus.irq_timer = 1'b0;
    bus.irq_sw    = 1'b0;
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] en, lines;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.csr_we = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
    bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_pc = 0; bus.exc_tval = 0;
    bus.mret_valid = 0; bus.irq_window = 0; bus.irq_pc = 0;
    bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_sw = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    foreach (addr_tbl[i]) csr_read_check(addr_tbl[i], $sformatf("reset %03h", addr_tbl[i]));
    csr_read_check(12'h7C5, "unimpl read");

    // Exception with direct mtvec.
    csr_write(12'h300, 32'h8);
    csr_write(12'h305, 32'h100);
    do_exception(2, 32'h40, 32'hDEAD, 1'b0, 1'b0, 32'h0, "exc");
    csr_read_check(12'h341, "exc mepc");
    csr_read_check(12'h342, "exc mcause");
    csr_read_check(12'h343, "exc mtval");
    csr_read_check(12'h300, "exc mstatus");

    // Timer interrupt with mtvec mode 1.
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h80);
    csr_write(12'h305, 32'h201);
    csr_read_check(12'h305, "mtvec mode");
    do_irq(1'b0, 1'b1, 1'b0, 32'h80, "timer irq");
    csr_read_check(12'h342, "timer mcause");
    csr_read_check(12'h343, "timer mtval");

    // mtvec reserved mode must not change the mode field.
    csr_write(12'h305, 32'h302);
    csr_read_check(12'h305, "mtvec warl");

    // All three lines pending: MEI wins.
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_read_check(12'h304, "mie mask");
    do_irq(1'b1, 1'b1, 1'b1, 32'h1234, "prio irq");
    csr_read_check(12'h342, "prio mcause");

    // Exception, MRET and a CSR write together: exception wins, write dropped.
    csr_write(12'h340, 32'hA5A5_0000);
    csr_write(12'h300, 32'h8);
    do_exception(4, 32'h203, 32'h11, 1'b1, 1'b1, 32'h5, "simul exc");
    csr_read_check(12'h340, "simul mscratch");
    csr_read_check(12'h300, "simul mstatus");
    csr_read_check(12'h341, "simul mepc");
    do_mret("simul mret");
    csr_read_check(12'h300, "mret mstatus");

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          if ($urandom_range(0, 12) == 0) a = 12'h7C0 + 12'($urandom_range(0, 63));
          else a = addr_tbl[$urandom_range(0, 12)];
          csr_write(a, $urandom);
          csr_read_check(a, $sformatf("rand %03h", a));
        end
        3: begin
          do_exception($urandom_range(0, 31), $urandom, $urandom, 1'($urandom), 1'($urandom),
                       $urandom, "rand exc");
          csr_read_check(12'h342, "rand exc mcause");
        end
        4: do_mret("rand mret");
        default: begin
          en = 32'h888 & $urandom;
          if (en == 0) en = 32'h80;
          csr_write(12'h300, 32'h8 | ($urandom & 32'h80));
          csr_write(12'h304, en);
          lines = ($urandom & 32'h888) | en;
          do_irq(lines[11], lines[7], lines[3], $urandom, "rand irq");
          csr_read_check(12'h342, "rand irq mcause");
          csr_read_check(12'h341, "rand irq mepc");
        end
      endcase
    end

    // Reset while in SAVE aborts the trap.
    csr_write(12'h305, 32'h300);
    @(negedge clk);
    bus.exc_valid = 1'b1;
    bus.exc_cause = 5'd5;
    bus.exc_pc    = 32'h1234;
    bus.exc_tval  = 32'h77;
    @(posedge clk);
    #1 bus.exc_valid = 1'b0;
    @(negedge clk);
    check("abort in save busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort redirect_valid", 32'(bus.redirect_valid), 32'd0);
      check("abort busy", 32'(bus.busy), 32'd0);
    end
    csr_read_check(12'h305, "abort mtvec");
    csr_read_check(12'h341, "abort mepc");
    csr_read_check(12'h300, "abort mstatus");
    csr_write(12'hF14, 32'hFFFF);
    csr_read_check(12'hF14, "mhartid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the machine register width (MXLEN).
REQ-002 The module SHALL have parameter HART_ID, default 0, giving the value read from mhartid.
REQ-003 The module SHALL have parameter RESET_VEC, default 32'h0000_0000, giving the reset value of mtvec.base concatenated with 2'b00.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 csr_we  in  1  CSR write strobe, from the CSR instruction in execute.
REQ-007 csr_addr  in  12  CSR address for read and write.
REQ-008 csr_wdata  in  XLEN  CSR write data.
REQ-009 csr_rdata  out  XLEN  combinational read data for csr_addr.
REQ-010 csr_illegal  out  1  combinational; addressed CSR is unimplemented, or is read-only with csr_we=1.
REQ-011 exc_valid, exc_cause[4:0], exc_pc[XLEN], exc_tval[XLEN]  in  synchronous exception request, with its cause, faulting PC and trap value.
REQ-012 mret_valid  in  1  MRET retiring.
REQ-013 irq_window  in  1; irq_pc  in  XLEN  pipeline can accept an interrupt; irq_pc is the PC to resume at.
REQ-014 irq_ext, irq_timer, irq_sw  in  1 each  level interrupt lines that drive mip.MEIP, mip.MTIP and mip.MSIP.
REQ-015 redirect_valid  out  1; redirect_pc  out  XLEN  one-cycle fetch redirect.
REQ-016 busy  out  1  FSM is not IDLE; upstream SHALL hold further exc_valid and mret_valid until busy=0.

Function
REQ-017 CSR map: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (read-only), mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14 (all four read-only, reading 0, 0, 0, HART_ID).
REQ-018 Unimplemented CSR reads SHALL return 0; csr_illegal SHALL be set for them.
REQ-019 Field rules: misa reads mxl=01 with only extension bit 8 (I) set; mstatus writable bits are MIE, MPIE and MPP, and MPP always reads 2'b11; mepc bits[1:0] are always 0; mie writable bits are 11, 7 and 3 only.
REQ-020 CSR writes SHALL commit at the next edge, only in IDLE, and only when csr_illegal=0; otherwise they SHALL be dropped.
REQ-021 FSM states: IDLE, SAVE, RESTORE, REDIR.
REQ-022 In IDLE the FSM SHALL select the highest-priority request: exc_valid first, then mret_valid, then interrupt.
REQ-023 An interrupt is taken when irq_window=1, mstatus.MIE=1, and (mip & mie) is non-zero.
REQ-024 Interrupt cause priority SHALL be MEI (11), then MSI (3), then MTI (7).
REQ-025 IDLE->SAVE on an exception or interrupt; at that edge:
- mepc <= exc_pc or irq_pc;
- mcause <= {interrupt, cause};
- mtval <= exc_tval (0 for an interrupt);
- MPIE <= MIE, MIE <= 0.
REQ-026 IDLE->RESTORE on mret_valid; at that edge MIE <= MPIE and MPIE <= 1.
REQ-027 SAVE->REDIR and RESTORE->REDIR SHALL occur unconditionally; in REDIR redirect_valid=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-028 Trap target: {mtvec.base, 2'b00}; for an interrupt with mtvec.mode=1, base + 4*cause. MRET target: mepc.
REQ-029 Latency: a request sampled in cycle N SHALL give redirect_valid in cycle N+2.
REQ-030 A csr_we arriving together with a winning trap or MRET SHALL be dropped.
REQ-031 mtvec.mode writes of 2 or 3 SHALL leave the mode field unchanged (WARL).

Reset
REQ-032 While rst_n=0 at a clock edge the following SHALL take their reset values:
- FSM <= IDLE; redirect_valid=0, busy=0;
- mstatus <= 0 with MPP=11;
- mtvec <= RESET_VEC;
- mie, mscratch, mepc, mcause, mtval <= 0.
REQ-033 Reset SHALL abort an in-flight trap; no redirect SHALL be issued afterwards.

Configuration
REQ-034 Macro TRAP_VECTORED_EN defined: mtvec.mode accepts values 0 and 1, and vectored targets apply to interrupts.
REQ-035 Macro TRAP_VECTORED_EN undefined: mtvec.mode is hardwired to 0, and every trap targets {mtvec.base, 2'b00}.

Verification
REQ-036 Exception: mtvec=0x100, exc_valid with cause 2, pc 0x40, tval 0xDEAD -> redirect 0x100 two cycles later; mepc=0x40, mcause=2, mtval=0xDEAD, MIE=0.
REQ-037 Vectored timer interrupt: TRAP_VECTORED_EN defined, mtvec=0x201, MIE=1, mie[7]=1, irq_timer=1, irq_window=1, irq_pc=0x80 -> redirect 0x21C; mcause=0x8000_0007.
REQ-038 Interrupt priority: irq_ext, irq_timer and irq_sw all set and enabled -> mcause=0x8000_000B.
REQ-039 Simultaneous events: exc_valid, mret_valid and csr_we (mscratch<=5) in the same cycle -> exception taken, mscratch unchanged; then MRET -> redirect to mepc, MIE restored.
REQ-040 Reset in SAVE: rst_n=0 for one cycle -> no redirect_valid; mtvec=RESET_VEC; csr_we to 0xF14 -> csr_illegal=1, value unchanged.
